// File: rtl/store_formatter_if.sv
// store_formatter_if: LSU request side and memory write-beat side
// of the store formatter, grouped as one handshake bundle.
interface store_formatter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    input  req_size,
    output req_ready,
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready
  );

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    output req_size,
    input  req_ready,
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready
  );
endinterface

// File: rtl/store_formatter.sv
// store_formatter: queues store requests and emits word-aligned write beats.
// Define MISALIGN_SPLIT_EN to split word-crossing stores into two beats.
module store_formatter #(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  store_formatter_if.slave bus,
  output logic             misalign_err,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } req_t;

  req_t        r_fifo [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_err;

  logic        w_full;
  logic        w_empty;
  logic        w_bad;
  logic        w_push;
  logic        w_pop;
  logic        w_fire;
  req_t        w_head;
  logic [1:0]  w_off;
  logic [31:0] w_base;
  logic [31:0] w_val;
  logic [3:0]  w_mask;

  assign w_full        = r_cnt == (AW+1)'(DEPTH);
  assign w_empty       = r_cnt == '0;
  assign w_head        = r_fifo[r_rp];
  assign w_off         = w_head.addr[1:0];
  assign w_base        = {w_head.addr[31:2], 2'b00};
  assign bus.req_ready = !w_full;
  assign bus.mem_valid = !w_empty;
  assign w_fire        = !w_empty & bus.mem_ready;
  assign w_push        = bus.req_valid & !w_full & !w_bad;
  assign misalign_err  = r_err;

  // Decide at accept time whether a request must be dropped.
  always_comb begin
    w_bad = 1'b0;
    unique case (1'b1)
      bus.req_size == 2'd3: w_bad = 1'b1;
`ifndef MISALIGN_SPLIT_EN
      bus.req_size == 2'd1: w_bad = bus.req_addr[0];
      bus.req_size == 2'd2: w_bad = |bus.req_addr[1:0];
`endif
      default: w_bad = 1'b0;
    endcase
  end

  // Size-mask the head data and pick its byte-lane mask.
  always_comb begin
    w_val  = w_head.data;
    w_mask = 4'b1111;
    case (w_head.size)
      2'd0: begin
        w_val  = {24'h0, w_head.data[7:0]};
        w_mask = 4'b0001;
      end
      2'd1: begin
        w_val  = {16'h0, w_head.data[15:0]};
        w_mask = 4'b0011;
      end
      default: ;
    endcase
  end

  // Store accepted requests; entries need no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wp] <= {bus.req_addr, bus.req_data, bus.req_size};
    end
  end

  // FIFO pointers, occupancy and the drop pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= bus.req_valid & !w_full & w_bad;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic {ST_FIRST, ST_SECOND} state_t;

  state_t      r_state;
  logic [63:0] w_d;
  logic [7:0]  w_s;
  logic        w_split;

  assign w_d     = {32'h0, w_val} << {w_off, 3'b000};
  assign w_s     = {4'h0, w_mask} << w_off;
  assign w_split = |w_s[7:4];
  assign w_pop   = w_fire & ((r_state == ST_SECOND) | !w_split);
  assign busy    = !w_empty | (r_state == ST_SECOND);

  // Beat mux: low word in FIRST, spill-over word in SECOND.
  always_comb begin
    bus.mem_addr  = w_base;
    bus.mem_wdata = w_d[31:0];
    bus.mem_wstrb = w_s[3:0];
    if (r_state == ST_SECOND) begin
      bus.mem_addr  = w_base + 32'd4;
      bus.mem_wdata = w_d[63:32];
      bus.mem_wstrb = w_s[7:4];
    end
  end

  // Two-beat sequencer for word-crossing stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FIRST;
    end else if (w_fire) begin
      unique case (r_state)
        ST_FIRST:  if (w_split) r_state <= ST_SECOND;
        ST_SECOND: r_state <= ST_FIRST;
      endcase
    end
  end
`else
  logic [31:0] w_d;
  logic [3:0]  w_s;

  assign w_d           = w_val << {w_off, 3'b000};
  assign w_s           = w_mask << w_off;
  assign w_pop         = w_fire;
  assign busy          = !w_empty;
  assign bus.mem_addr  = w_base;
  assign bus.mem_wdata = w_d;
  assign bus.mem_wstrb = w_s;
`endif

endmodule

// File: tb/tb_store_formatter.sv
// tb_store_formatter: directed and randomized checks of store_formatter
// against a byte-by-byte reference model.
module tb_store_formatter;
  logic clock;
  logic reset;
  logic misalign_err;
  logic busy;
  int   n_checks;
  int   n_pass;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t exp[$];

  store_formatter_if bus();

  store_formatter #(.DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .misalign_err(misalign_err),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: place each stored byte at its absolute address.
  function automatic bit model_push(input logic [31:0] a,
                                    input logic [31:0] d,
                                    input logic [1:0]  sz);
    int          n;
    int          lane;
    bit          mis;
    logic [31:0] w0;
    logic [31:0] ba;
    beat_t       b0;
    beat_t       b1;
    if (sz == 2'd3) return 1'b1;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (int'(a[1:0]) % n) != 0;
`ifndef MISALIGN_SPLIT_EN
    if (mis) return 1'b1;
`endif
    w0 = a & ~32'd3;
    b0 = '{w0, 32'h0, 4'h0};
    b1 = '{w0 + 32'd4, 32'h0, 4'h0};
    for (int i = 0; i < n; i++) begin
      ba   = a + 32'(i);
      lane = int'(ba[1:0]);
      if ((ba & ~32'd3) == w0) begin
        b0.data[8*lane +: 8] = d[8*i +: 8];
        b0.strb[lane] = 1'b1;
      end else begin
        b1.data[8*lane +: 8] = d[8*i +: 8];
        b1.strb[lane] = 1'b1;
      end
    end
    exp.push_back(b0);
    if (b1.strb != 4'h0) exp.push_back(b1);
    return 1'b0;
  endfunction

  // Offer one request; returns at the negedge after it is accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz);
    int n;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = sz;
    n = 0;
    #1;
    while (!bus.req_ready && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    n_checks++;
    if (n >= 40) $display("FAIL send_timeout: addr %h not accepted", a);
    else n_pass++;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (bus.mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b want 0", bus.mem_valid);
    else n_pass++;
    n_checks++;
    if (misalign_err !== 1'b0) $display("FAIL rst_err: got %b want 0", misalign_err);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_byte_half;
    bus.mem_ready = 1'b0;
    send(32'h1003, 32'h000000AB, 2'd0);
    #1;
    n_checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h1000 || bus.mem_wdata !== 32'hAB000000 || bus.mem_wstrb !== 4'b1000)
      $display("FAIL sb_beat: got v=%b %h/%h/%b want 1 00001000/ab000000/1000", bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL sb_busy: got %b want 1", busy);
    else n_pass++;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL sb_drain: got v=%b busy=%b want 0 0", bus.mem_valid, busy);
    else n_pass++;
    bus.mem_ready = 1'b0;
    send(32'h2002, 32'h1234BEEF, 2'd1);
    #1;
    n_checks++;
    if (bus.mem_addr !== 32'h2000 || bus.mem_wdata !== 32'hBEEF0000 || bus.mem_wstrb !== 4'b1100)
      $display("FAIL sh_beat: got %h/%h/%b want 00002000/beef0000/1100", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_full;
    int got;
    bit acc;
    got = 0;
    acc = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i), 2'd2);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h110;
    bus.req_data  = 32'hC0DE0004;
    bus.req_size  = 2'd2;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0 || busy !== 1'b1) $display("FAIL full_hold: got ready=%b busy=%b want 0 1", bus.req_ready, busy);
    else n_pass++;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (bus.mem_valid) begin
        n_checks++;
        if (bus.mem_addr !== 32'h100 + 32'(4*got) || bus.mem_wdata !== 32'hC0DE0000 + 32'(got))
          $display("FAIL full_order: beat %0d got %h/%h", got, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        got++;
      end
      if (bus.req_valid && bus.req_ready) acc = 1'b1;
      @(negedge clock);
      if (acc) bus.req_valid = 1'b0;
      #1;
    end
    n_checks++;
    if (got != 5 || !acc) $display("FAIL full_drain: got %0d beats acc=%b want 5 1", got, acc);
    else n_pass++;
    @(negedge clock);
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_misalign;
    bus.mem_ready = 1'b0;
    send(32'h3001, 32'hAABBCCDD, 2'd2);
    #1;
`ifdef MISALIGN_SPLIT_EN
    n_checks++;
    if (bus.mem_addr !== 32'h3000 || bus.mem_wdata !== 32'hBBCCDD00 || bus.mem_wstrb !== 4'b1110)
      $display("FAIL mis_beat0: got %h/%h/%b want 00003000/bbccdd00/1110", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h3004 || bus.mem_wdata !== 32'h000000AA || bus.mem_wstrb !== 4'b0001)
      $display("FAIL mis_beat1: got v=%b %h/%h/%b want 1 00003004/000000aa/0001", bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.mem_valid !== 1'b0 || busy !== 1'b0 || misalign_err !== 1'b0)
      $display("FAIL mis_done: got v=%b busy=%b err=%b want 0 0 0", bus.mem_valid, busy, misalign_err);
    else n_pass++;
`else
    n_checks++;
    if (misalign_err !== 1'b1 || bus.mem_valid !== 1'b0)
      $display("FAIL mis_drop: got err=%b v=%b want 1 0", misalign_err, bus.mem_valid);
    else n_pass++;
    @(negedge clock);
    #1;
    n_checks++;
    if (misalign_err !== 1'b0 || busy !== 1'b0) $display("FAIL mis_pulse: got err=%b busy=%b want 0 0", misalign_err, busy);
    else n_pass++;
`endif
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reserved;
    bus.mem_ready = 1'b0;
    send(32'h50, 32'h1, 2'd3);
    #1;
    n_checks++;
    if (misalign_err !== 1'b1 || bus.mem_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rsv_drop: got err=%b v=%b busy=%b want 1 0 0", misalign_err, bus.mem_valid, busy);
    else n_pass++;
    @(negedge clock);
    #1;
    n_checks++;
    if (misalign_err !== 1'b0) $display("FAIL rsv_pulse: got %b want 0", misalign_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bus.mem_ready = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    send(32'hFFFFFFFE, 32'h11223344, 2'd2);
    #1;
    n_checks++;
    if (bus.mem_addr !== 32'hFFFFFFFC || bus.mem_wdata !== 32'h33440000 || bus.mem_wstrb !== 4'b1100)
      $display("FAIL wrap_beat0: got %h/%h/%b want fffffffc/33440000/1100", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h00001122 || bus.mem_wstrb !== 4'b0011)
      $display("FAIL wrap_beat1: got %h/%h/%b want 00000000/00001122/0011", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
`else
    send(32'h40, 32'h0BAD0001, 2'd2);
    send(32'h44, 32'h0BAD0002, 2'd2);
`endif
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL midrst: got v=%b busy=%b ready=%b want 0 0 1", bus.mem_valid, busy, bus.req_ready);
    else n_pass++;
    send(32'h1003, 32'h000000AB, 2'd0);
    #1;
    n_checks++;
    if (bus.mem_addr !== 32'h1000 || bus.mem_wdata !== 32'hAB000000 || bus.mem_wstrb !== 4'b1000)
      $display("FAIL midrst_next: got %h/%h/%b want 00001000/ab000000/1000", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    else n_pass++;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_random;
    bit          have;
    bit          err_prev;
    bit          done;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    beat_t       b;
    have     = 1'b0;
    err_prev = 1'b0;
    a        = '0;
    d        = '0;
    sz       = '0;
    exp.delete();
    for (int c = 0; c < 440; c++) begin
      @(negedge clock);
      if (c >= 400) have = 1'b0;
      else if (!have && $urandom_range(0, 2) != 0) begin
        have = 1'b1;
        a    = $urandom;
        if ($urandom_range(0, 5) == 0) a[31:2] = '1;
        d    = $urandom;
        sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      end
      bus.req_valid = have;
      bus.req_addr  = a;
      bus.req_data  = d;
      bus.req_size  = sz;
      bus.mem_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (misalign_err !== err_prev) $display("FAIL rnd_err: cycle %0d got %b want %b", c, misalign_err, err_prev);
      else n_pass++;
      err_prev = 1'b0;
      n_checks++;
      if (bus.mem_valid !== (exp.size() != 0)) $display("FAIL rnd_valid: cycle %0d got %b want %b", c, bus.mem_valid, exp.size() != 0);
      else n_pass++;
      if (bus.mem_valid && bus.mem_ready && exp.size() != 0) begin
        b = exp.pop_front();
        n_checks++;
        if (bus.mem_addr !== b.addr || bus.mem_wdata !== b.data || bus.mem_wstrb !== b.strb)
          $display("FAIL rnd_beat: cycle %0d got %h/%h/%b want %h/%h/%b", c, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, b.addr, b.data, b.strb);
        else n_pass++;
      end
      if (have && bus.req_ready) begin
        err_prev = model_push(a, d, sz);
        have     = 1'b0;
      end
    end
    done = (exp.size() == 0) && !busy;
    n_checks++;
    if (!done) $display("FAIL rnd_drain: %0d beats left busy=%b", exp.size(), busy);
    else n_pass++;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_byte_half();
    test_full();
    test_misalign();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
